// File: rtl/dmem_cache_if.sv
// Requester and DRAM-side signal bundle for the direct-mapped data cache.
// slave is the cache's view; master is the requester/memory side.
interface dmem_cache_if #(
   parameter int unsigned APP_ADDR_WIDTH = 28
);
   logic                        i_ren;
   logic [3:0]                  i_wen;
   logic [31:0]                 i_addr;
   logic [31:0]                 i_data;
   logic [31:0]                 o_data;
   logic                        o_stall;
   logic                        i_flush;
   logic                        o_flush_done;
   logic                        o_dram_ren;
   logic                        o_dram_wen;
   logic [APP_ADDR_WIDTH-2:0]   o_dram_addr;
   logic [127:0]                o_dram_data;
   logic [15:0]                 o_dram_mask;
   logic                        i_dram_calib_complete;
   logic [127:0]                i_dram_data;
   logic                        i_dram_data_valid;
   logic                        i_dram_busy;

   modport master (
      output i_ren, i_wen, i_addr, i_data, i_flush,
             i_dram_calib_complete, i_dram_data, i_dram_data_valid, i_dram_busy,
      input  o_data, o_stall, o_flush_done,
             o_dram_ren, o_dram_wen, o_dram_addr, o_dram_data, o_dram_mask
   );

   modport slave (
      input  i_ren, i_wen, i_addr, i_data, i_flush,
             i_dram_calib_complete, i_dram_data, i_dram_data_valid, i_dram_busy,
      output o_data, o_stall, o_flush_done,
             o_dram_ren, o_dram_wen, o_dram_addr, o_dram_data, o_dram_mask
   );
endinterface

// File: rtl/dmem_cache.sv
// Direct-mapped write-back data cache with 128-bit lines in front of a DRAM
// application port; zero-stall hits, write-back on dirty eviction, full flush.
module dmem_cache #(
   parameter int unsigned APP_ADDR_WIDTH = 28,
   parameter int unsigned INDEX_WIDTH    = 6
) (
   input logic          clk,
   input logic          rst,
   dmem_cache_if.slave  bus
);
   localparam int unsigned LINES = 2 ** INDEX_WIDTH;
   localparam int unsigned TAG_W = APP_ADDR_WIDTH - INDEX_WIDTH - 4;
   localparam int unsigned CNT_W = INDEX_WIDTH + 1;

   typedef enum logic [2:0] {
      S_CALIB, S_IDLE, S_WB, S_FILL, S_FILL_WAIT, S_FLUSH_SCAN, S_FLUSH_WB
   } state_t;

   state_t state, next_state;

   logic [LINES-1:0]   valid;
   logic [LINES-1:0]   dirty;
   logic [TAG_W-1:0]   tags  [LINES];
   logic [127:0]       lines [LINES];
   logic [CNT_W-1:0]   cnt;

   logic [1:0]             word_sel;
   logic [INDEX_WIDTH-1:0] req_idx;
   logic [TAG_W-1:0]       req_tag;
   logic [INDEX_WIDTH-1:0] scan_idx;
   logic [INDEX_WIDTH-1:0] wb_idx;
   logic                   is_wr, is_req, hit, victim_dirty, scan_dirty, scan_end;
   logic [31:0]            hit_word;
   logic [127:0]           wr_line;
   logic                   unused_addr_bits;

   assign word_sel     = bus.i_addr[3:2];
   assign req_idx      = bus.i_addr[INDEX_WIDTH+3:4];
   assign req_tag      = bus.i_addr[APP_ADDR_WIDTH-1:INDEX_WIDTH+4];
   assign scan_idx     = cnt[INDEX_WIDTH-1:0];
   assign scan_end     = cnt[INDEX_WIDTH];
   assign wb_idx       = (state == S_FLUSH_WB) ? scan_idx : req_idx;
   assign is_wr        = |bus.i_wen;
   assign is_req       = is_wr | bus.i_ren;
   assign hit          = valid[req_idx] && (tags[req_idx] == req_tag);
   assign victim_dirty = valid[req_idx] && dirty[req_idx];
   assign scan_dirty   = valid[scan_idx] && dirty[scan_idx];
   assign hit_word     = lines[req_idx][{word_sel, 5'b00000} +: 32];
   assign unused_addr_bits = ^{bus.i_addr[1:0], bus.i_addr[31:APP_ADDR_WIDTH]};

   // Byte-lane merge of the write data into the addressed line
   always_comb begin
      wr_line = lines[req_idx];
      for (int b = 0; b < 4; b++) begin
         if (bus.i_wen[b]) wr_line[{word_sel, 2'(b), 3'b000} +: 8] = bus.i_data[8*b +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_CALIB;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         S_CALIB:      if (bus.i_dram_calib_complete) next_state = S_IDLE;
         S_IDLE: begin
            if (is_req && !hit)     next_state = victim_dirty ? S_WB : S_FILL;
            else if (!is_req && bus.i_flush) next_state = S_FLUSH_SCAN;
         end
         S_WB:         if (!bus.i_dram_busy) next_state = S_FILL;
         S_FILL:       if (!bus.i_dram_busy) next_state = S_FILL_WAIT;
         S_FILL_WAIT:  if (bus.i_dram_data_valid) next_state = S_IDLE;
         S_FLUSH_SCAN: begin
            if (scan_end)        next_state = S_IDLE;
            else if (scan_dirty) next_state = S_FLUSH_WB;
         end
         S_FLUSH_WB:   if (!bus.i_dram_busy) next_state = S_FLUSH_SCAN;
         default:      next_state = S_CALIB;
      endcase
   end

   // Requester and DRAM outputs; reset forces the idle-safe values
   always_comb begin
      bus.o_stall      = 1'b1;
      bus.o_data       = '0;
      bus.o_flush_done = 1'b0;
      bus.o_dram_ren   = 1'b0;
      bus.o_dram_wen   = 1'b0;
      bus.o_dram_addr  = '0;
      bus.o_dram_data  = '0;
      bus.o_dram_mask  = '0;
      if (!rst) begin
         unique case (state)
            S_IDLE: begin
               bus.o_stall = is_req && !hit;
               if (is_req && hit && !is_wr) bus.o_data = hit_word;
            end
            S_WB, S_FLUSH_WB: begin
               bus.o_dram_wen  = !bus.i_dram_busy;
               bus.o_dram_addr = {tags[wb_idx], wb_idx, 3'b000};
               bus.o_dram_data = lines[wb_idx];
            end
            S_FILL: begin
               bus.o_dram_ren  = !bus.i_dram_busy;
               bus.o_dram_addr = {req_tag, req_idx, 3'b000};
            end
            S_FLUSH_SCAN: bus.o_flush_done = scan_end;
            default: ;
         endcase
      end
   end

   // Line state bits and flush scan counter
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= '0;
         dirty <= '0;
         cnt   <= '0;
      end else begin
         if (state == S_IDLE && is_wr && hit) dirty[req_idx] <= 1'b1;
         if (state == S_IDLE && !is_req && bus.i_flush) cnt <= '0;
         if (state == S_FILL_WAIT && bus.i_dram_data_valid) begin
            valid[req_idx] <= 1'b1;
            dirty[req_idx] <= 1'b0;
         end
         if (state == S_FLUSH_SCAN && !scan_end && !scan_dirty) cnt <= cnt + CNT_W'(1);
         if (state == S_FLUSH_WB && !bus.i_dram_busy) begin
            dirty[scan_idx] <= 1'b0;
            cnt             <= cnt + CNT_W'(1);
         end
      end
   end

   // Tag and data storage carry no reset
   always_ff @(posedge clk) begin
      if (!rst && state == S_IDLE && is_wr && hit) lines[req_idx] <= wr_line;
      if (!rst && state == S_FILL_WAIT && bus.i_dram_data_valid) begin
         lines[req_idx] <= bus.i_dram_data;
         tags[req_idx]  <= req_tag;
      end
   end
endmodule

// File: doc/dmem_cache.md
DMEM_CACHE -- requirements
Module: dmem_cache

Interface
REQ-001 SHALL have parameter APP_ADDR_WIDTH, default 28, DRAM application address width.
REQ-002 SHALL have parameter INDEX_WIDTH, default 6, giving 2**INDEX_WIDTH direct-mapped lines of 128 bits.
REQ-003 SHALL have ports: clk in 1, clock; rst in 1, reset, synchronous, active-high.
REQ-004 SHALL have ports: i_ren in 1, read request; i_wen in 4, byte write enables; i_addr in 32, byte address; i_data in 32, write data.
REQ-005 SHALL have ports: o_data out 32, read data; o_stall out 1, requester holds request while high.
REQ-006 SHALL have ports: i_flush in 1, flush pulse; o_flush_done out 1, one-cycle completion pulse.
REQ-007 SHALL have DRAM-side ports:
- o_dram_ren out 1
- o_dram_wen out 1
- o_dram_addr out APP_ADDR_WIDTH-1
- o_dram_data out 128
- o_dram_mask out 16, 1 = byte disabled
- i_dram_calib_complete in 1
- i_dram_data in 128
- i_dram_data_valid in 1
- i_dram_busy in 1

Function
REQ-008 SHALL decode i_addr as follows:
- word select = addr[3:2]
- index = addr[INDEX_WIDTH+3:4]
- tag = addr[APP_ADDR_WIDTH-1:INDEX_WIDTH+4]
- addr[1:0] and addr[31:APP_ADDR_WIDTH] ignored
REQ-009 SHALL keep per line: valid bit, dirty bit, tag, 128-bit data; word w occupies bits [32w+31:32w].
REQ-010 SHALL implement states CALIB, IDLE, WB, FILL, FILL_WAIT, FLUSH_SCAN, FLUSH_WB.
REQ-011 CALIB: o_stall=1; go to IDLE when i_dram_calib_complete=1.
REQ-012 In IDLE, a request is i_wen!=0 or i_ren=1; i_wen!=0 takes priority over i_ren (treated as write).
REQ-013 In IDLE, hit = valid && tag match. On hit:
- o_stall=0 in the same cycle (zero-stall hit).
- Read: o_data = selected word, combinational, same cycle.
- Write: update only enabled byte lanes at the next edge; set dirty.
REQ-014 o_stall=0 in IDLE with no request; o_data=0 whenever no read hit is being served.
REQ-015 On miss: o_stall=1; go to WB if victim valid&&dirty, else go to FILL.
REQ-016 WB: o_dram_wen = !i_dram_busy; o_dram_addr = {victim tag, index, 3'b000}; o_dram_data = victim line; o_dram_mask=0; go to FILL on the cycle o_dram_wen=1.
REQ-017 FILL: o_dram_ren = !i_dram_busy; o_dram_addr = {request tag, index, 3'b000}; go to FILL_WAIT on the cycle o_dram_ren=1.
REQ-018 FILL_WAIT: on i_dram_data_valid, write i_dram_data to the line, set tag, valid=1, dirty=0, and go to IDLE; the held request then hits, i.e. miss latency ends with one hit cycle in IDLE.
REQ-019 o_dram_ren/o_dram_wen SHALL never assert outside FILL/WB/FLUSH_WB, and never while i_dram_busy=1.
REQ-020 Flush: an i_flush seen in IDLE with no request SHALL go to FLUSH_SCAN with counter=0; a request in the same cycle wins and the flush is dropped.
REQ-021 FLUSH_SCAN: if line[counter] is valid&&dirty, go to FLUSH_WB; else increment. After the last index, pulse o_flush_done=1 for one cycle and return to IDLE.
REQ-022 FLUSH_WB: issue the line write as in REQ-016, clear dirty (valid kept), increment counter, return to FLUSH_SCAN.
REQ-023 o_stall=1 for any request presented during flush; i_flush outside IDLE SHALL be ignored.
REQ-024 Counter SHALL be INDEX_WIDTH+1 bits; no wrap to index 0 after the last line.

Reset
REQ-025 On rst: state=CALIB; all valid and dirty bits=0; flush counter=0.
REQ-026 On rst: o_stall=1, o_dram_ren=0, o_dram_wen=0, o_flush_done=0, o_data=0; tag/data contents not reset.
REQ-027 rst mid-operation (any state) SHALL abandon the transaction; dirty data is lost, and no DRAM command SHALL be issued in the cycle after rst.

Verification
REQ-028 Cold read of 0x0000_0040 after calib -> one o_dram_ren with o_dram_addr=0x20, data 128'h...DDDD_CCCC_BBBB_AAAA returned -> o_data=0xAAAA..., with o_stall released exactly one cycle after valid.
REQ-029 Write 0x12345678 with i_wen=4'b0011 to 0x44 (hit) -> o_stall=0 same cycle; next read of 0x44 returns low half updated, high half unchanged, with no DRAM traffic.
REQ-030 Dirty victim: dirty line at index 4, then read an address with the same index and a different tag -> o_dram_wen with the old tag address and mask 0, then o_dram_ren, in that order.
REQ-031 i_dram_busy held high 10 cycles in WB and FILL -> no command asserted while busy; exactly one command each after release.
REQ-032 Dirty lines at indices 0 and 63, then i_flush -> exactly two o_dram_wen, o_flush_done single pulse, dirty bits cleared; a subsequent read hit needs no DRAM access.
REQ-033 rst asserted in FILL_WAIT -> state CALIB, all lines invalid, o_stall=1; a late i_dram_data_valid is ignored.
